// File: rtl/inst_queue_pkg.sv
// Shared types and helpers for the fetch-to-issue instruction queue.
package inst_queue_pkg;

    localparam int DEF_INST_W = 32;
    localparam int DEF_PC_W   = 32;

    typedef struct packed {
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_PC_W-1:0]   pc;
    } iq_entry_t;

    // Number of consecutive ones starting at bit 0, looking at the low n bits only.
    function automatic int lead_ones(input logic [31:0] bits, input int n);
        int   k;
        logic run;
        k   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i < n && run) begin
                if (bits[i]) k++;
                else         run = 1'b0;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/inst_queue_lane_compact.sv
// Maps sparse fetch lanes to dense write offsets; offset of lane i = valid lanes below it.
module lane_compact #(
    parameter int FETCH_W = 2,
    parameter int OFF_W   = $clog2(FETCH_W + 1)
) (
    input  logic [FETCH_W-1:0]            in_valid,
    output logic [FETCH_W-1:0][OFF_W-1:0] offset,
    output logic [OFF_W-1:0]              total
);

    logic [OFF_W-1:0] acc;

    always_comb begin
        acc    = '0;
        offset = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            offset[i] = acc;
            acc       = acc + OFF_W'(in_valid[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane circular instruction queue: compacting push, in-order fall-through pop, flush.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int INST_W  = DEF_INST_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int DEPTH   = 16,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [FETCH_W-1:0]        in_valid,
    input  logic [FETCH_W*INST_W-1:0] in_inst,
    input  logic [FETCH_W*PC_W-1:0]   in_pc,
    output logic                      in_ready,
    output logic [ISSUE_W-1:0]        out_valid,
    output logic [ISSUE_W*INST_W-1:0] out_inst,
    output logic [ISSUE_W*PC_W-1:0]   out_pc,
    input  logic [ISSUE_W-1:0]        out_accept,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OFF_W = $clog2(FETCH_W + 1);

    logic [DEPTH-1:0][INST_W-1:0]   mem_inst;
    logic [DEPTH-1:0][PC_W-1:0]     mem_pc;
    logic [PTR_W-1:0]               head, tail;
    logic [FETCH_W-1:0][OFF_W-1:0]  offset;
    logic [OFF_W-1:0]               vld_cnt;
    logic                           push;
    logic [CNT_W-1:0]               push_n, pop_n;

    lane_compact #(.FETCH_W(FETCH_W), .OFF_W(OFF_W)) u_compact (
        .in_valid (in_valid),
        .offset   (offset),
        .total    (vld_cnt)
    );

    // Registered count only, so no combinational path from in_valid/out_accept.
    assign in_ready = (count <= CNT_W'(DEPTH - FETCH_W));
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign push     = in_ready && !flush;
    assign push_n   = push ? CNT_W'(vld_cnt) : '0;
    // out_valid is a thermometer, so masking accept by it drops invalid lanes.
    assign pop_n    = CNT_W'(lead_ones(32'(out_accept & out_valid), ISSUE_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + push_n - pop_n;
        end
    end

    // Storage is deliberately unreset; output masking hides stale entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (push && in_valid[i]) begin
                mem_inst[tail + PTR_W'(offset[i])] <= in_inst[i*INST_W +: INST_W];
                mem_pc[tail + PTR_W'(offset[i])]   <= in_pc[i*PC_W +: PC_W];
            end
        end
    end

    for (genvar i = 0; i < ISSUE_W; i++) begin : g_out
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx                     = head + PTR_W'(i);
        assign out_valid[i]               = (count > CNT_W'(i));
        assign out_inst[i*INST_W +: INST_W] = out_valid[i] ? mem_inst[rd_idx] : '0;
        assign out_pc[i*PC_W +: PC_W]       = out_valid[i] ? mem_pc[rd_idx]   : '0;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed table-driven bench for inst_queue at DEPTH=8, FETCH_W=2, ISSUE_W=2.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_inst;
    logic [63:0] in_pc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic [1:0]  out_accept;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    int checks   = 0;
    int failures = 0;

    inst_queue #(.INST_W(32), .PC_W(32), .DEPTH(8), .FETCH_W(2), .ISSUE_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_inst   (out_inst),
        .out_pc     (out_pc),
        .out_accept (out_accept),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          fl;
        logic [1:0]  vld;
        logic [31:0] p0, p1;
        logic [1:0]  acc;
        int          ecnt;
        logic [31:0] e0, e1;
        bit          erdy;
    } vec_t;

    vec_t rows[$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], 16'hBEEF};
    endfunction

    function automatic void add(input bit fl, input logic [1:0] vld, input logic [31:0] p0,
                                input logic [31:0] p1, input logic [1:0] acc, input int ecnt,
                                input logic [31:0] e0, input logic [31:0] e1, input bit erdy);
        vec_t r;
        r.fl = fl; r.vld = vld; r.p0 = p0; r.p1 = p1; r.acc = acc;
        r.ecnt = ecnt; r.e0 = e0; r.e1 = e1; r.erdy = erdy;
        rows.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs for a given occupancy and the two oldest pcs.
    task automatic chk_state(input string tag, input int ecnt, input logic [31:0] e0,
                             input logic [31:0] e1, input bit erdy);
        logic [1:0]  ev;
        logic [31:0] x0, x1, i0, i1;
        ev = {ecnt > 1, ecnt > 0};
        x0 = ev[0] ? e0 : 32'h0;
        x1 = ev[1] ? e1 : 32'h0;
        i0 = ev[0] ? inst_of(e0) : 32'h0;
        i1 = ev[1] ? inst_of(e1) : 32'h0;
        chk({tag, ".count"},     64'(count),     64'(ecnt));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, ".out_pc"},    out_pc,         {x1, x0});
        chk({tag, ".out_inst"},  out_inst,       {i1, i0});
        chk({tag, ".in_ready"},  64'(in_ready),  64'(erdy));
        chk({tag, ".empty"},     64'(empty),     64'(ecnt == 0));
        chk({tag, ".full"},      64'(full),      64'(ecnt == 8));
    endtask

    initial begin
        // fl vld p0 p1 acc | count pc0 pc1 ready
        add(0, 2'b11, 32'h1,  32'h2,  2'b00, 2, 32'h1,  32'h2,  1);
        add(0, 2'b11, 32'h3,  32'h4,  2'b00, 4, 32'h1,  32'h2,  1);
        add(0, 2'b11, 32'h5,  32'h6,  2'b00, 6, 32'h1,  32'h2,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 4, 32'h3,  32'h4,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 2, 32'h5,  32'h6,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 0, 32'h0,  32'h0,  1);
        // head = tail = 6: four entries straddle index 7 -> 0
        add(0, 2'b11, 32'h11, 32'h12, 2'b00, 2, 32'h11, 32'h12, 1);
        add(0, 2'b11, 32'h13, 32'h14, 2'b00, 4, 32'h11, 32'h12, 1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b01, 3, 32'h12, 32'h13, 1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 1, 32'h14, 32'h0,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b01, 0, 32'h0,  32'h0,  1);
        // sparse lanes, gapped accept, simultaneous push/pop
        add(0, 2'b10, 32'hDEAD, 32'hA, 2'b00, 1, 32'hA,  32'h0,  1);
        add(0, 2'b01, 32'hB,  32'hDEAD, 2'b00, 2, 32'hA, 32'hB,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b10, 2, 32'hA,  32'hB,  1);
        add(0, 2'b01, 32'hC,  32'h0,  2'b00, 3, 32'hA,  32'hB,  1);
        add(0, 2'b11, 32'hD,  32'hE,  2'b01, 4, 32'hB,  32'hC,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b10, 4, 32'hB,  32'hC,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b01, 3, 32'hC,  32'hD,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 1, 32'hE,  32'h0,  1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 0, 32'h0,  32'h0,  1);
        // fill to 7, held group refused, pop 1, group accepted -> full
        add(0, 2'b11, 32'h21, 32'h22, 2'b00, 2, 32'h21, 32'h22, 1);
        add(0, 2'b11, 32'h23, 32'h24, 2'b00, 4, 32'h21, 32'h22, 1);
        add(0, 2'b11, 32'h25, 32'h26, 2'b00, 6, 32'h21, 32'h22, 1);
        add(0, 2'b01, 32'h27, 32'h0,  2'b00, 7, 32'h21, 32'h22, 0);
        add(0, 2'b11, 32'h31, 32'h32, 2'b00, 7, 32'h21, 32'h22, 0);
        add(0, 2'b11, 32'h31, 32'h32, 2'b01, 6, 32'h22, 32'h23, 1);
        add(0, 2'b11, 32'h31, 32'h32, 2'b00, 8, 32'h22, 32'h23, 0);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 6, 32'h24, 32'h25, 1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 4, 32'h26, 32'h27, 1);
        add(0, 2'b00, 32'h0,  32'h0,  2'b11, 2, 32'h31, 32'h32, 1);
        // flush beats push and pop; next push lands normally
        add(1, 2'b11, 32'h41, 32'h42, 2'b11, 0, 32'h0,  32'h0,  1);
        add(0, 2'b11, 32'h43, 32'h44, 2'b00, 2, 32'h43, 32'h44, 1);

        rst = 1'b0; flush = 1'b0; in_valid = '0; in_inst = '0; in_pc = '0; out_accept = '0;
        @(posedge clk); #1;
        chk_state("reset", 0, 32'h0, 32'h0, 1);
        rst = 1'b1;

        for (int r = 0; r < rows.size(); r++) begin
            flush      = rows[r].fl;
            in_valid   = rows[r].vld;
            in_pc      = {rows[r].p1, rows[r].p0};
            in_inst    = {inst_of(rows[r].p1), inst_of(rows[r].p0)};
            out_accept = rows[r].acc;
            @(posedge clk); #1;
            chk_state($sformatf("row%0d", r), rows[r].ecnt, rows[r].e0, rows[r].e1, rows[r].erdy);
        end

        // Mid-stream async reset clears outputs without a clock edge.
        flush = 1'b0; in_valid = 2'b11; out_accept = 2'b00;
        in_pc = {32'h52, 32'h51}; in_inst = {inst_of(32'h52), inst_of(32'h51)};
        @(posedge clk); #1;
        in_valid = 2'b00;
        chk_state("pre_rst", 4, 32'h43, 32'h44, 1);
        #2 rst = 1'b0;
        #1 chk_state("async_rst", 0, 32'h0, 32'h0, 1);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised multi-lane instruction queue between the fetch stage and decode/issue. Fetch delivers up to FETCH_W instruction/PC pairs per cycle with per-lane valid bits. Issue drains up to ISSUE_W pairs per cycle in program order. It replaces the fixed two-in/two-out instruction buffer with configurable width and depth, a ready/valid handshake, lane compaction, occupancy reporting and flush.

## Interface
- INST_W, 32, instruction width
- PC_W, 32, PC width
- DEPTH, 16, entries; power of two, ≥ max(FETCH_W, ISSUE_W)
- FETCH_W, 2, input lanes
- ISSUE_W, 2, output lanes
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  discard all contents (branch mispredict / exception)
- in_valid  in  FETCH_W  per-lane valid; gaps allowed
- in_inst  in  FETCH_W*INST_W  lane i at [i*INST_W +: INST_W]
- in_pc  in  FETCH_W*PC_W  lane i at [i*PC_W +: PC_W]
- in_ready  out  1  queue accepts a full fetch group this cycle
- out_valid  out  ISSUE_W  thermometer: lane i valid iff count > i
- out_inst  out  ISSUE_W*INST_W  oldest entries, lane 0 oldest; zero when lane invalid
- out_pc  out  ISSUE_W*PC_W  as out_inst
- out_accept  in  ISSUE_W  consumer takes lanes; pop count = number of leading ones from lane 0
- count  out  $clog2(DEPTH)+1  current occupancy
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage is a circular array of {inst, pc} with head (read) and tail (write) pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH. Count is held in a separate register.
- Push: when in_ready is high and in_valid is non-zero, the valid lanes are compacted in lane order. They are written to tail, tail+1, and so on. Tail advances by popcount(in_valid).
- in_ready = (DEPTH − count) ≥ FETCH_W. It is computed from the registered count only, so there is no combinational path from out_accept or in_valid.
- in_valid with in_ready low: nothing is written. The producer must hold its data.
- Pop: n = number of leading ones in out_accept, with only lanes where out_valid is high counted. Head advances by n.
- Accept bits after the first zero are ignored. Accept on an invalid lane is ignored.
- Outputs are fall-through. Lane i shows entry head+i, combinationally from storage.
- Simultaneous push and pop: count_next = count + pushed − popped. Both take effect on the same edge.
- Flush has priority over push and pop in the same cycle. head, tail and count go to 0, and that cycle's push and pop are discarded.
- Entry storage is not reset. Output masking hides stale data.

## Timing
- Reset (rst low, asynchronous): head = tail = count = 0, so out_valid = 0, out_inst = out_pc = 0, empty = 1, full = 0, in_ready = 1 (given DEPTH ≥ FETCH_W).
- Reset asserted mid-operation clears the queue immediately, with no edge required.
- Push-to-visible latency is 1 cycle. Data written at edge k appears on out_* after edge k.
- Pop is effective at the edge. The next entries appear after that edge.
- Flush at edge k: out_valid = 0 after edge k. A push in cycle k+1 is accepted normally.
- Wrap-around: a group straddling index DEPTH−1 to 0 is written contiguously modulo DEPTH. Output lanes straddling the wrap read correctly.
- Full: count == DEPTH. in_ready is low whenever free space is below FETCH_W, even if fewer lanes are valid.

## Structure
- Shared package `inst_queue_pkg`: INST_W and PC_W defaults, typedef `iq_entry_t` {inst, pc}, and function `lead_ones` used for the pop count.
- Sub-module `lane_compact`: combinational. It maps sparse in_valid lanes to dense write offsets and outputs the popcount.
- Pointer, count and storage logic stay in `inst_queue`.

## Test plan
All scenarios use DEPTH=8, FETCH_W=2, ISSUE_W=2.
- Reset, then push {pc 0x1, 0x2}, {0x3, 0x4}, {0x5, 0x6} with no accept. Required: count=6, in_ready=1. Then out_accept=2'b11 for 3 cycles. Required: out_pc pairs (1,2), (3,4), (5,6), then empty=1 and out_pc=0.
- Fill to count=7. Required: in_ready=0, and a held in_valid=2'b11 group is not written. Pop 1. Required: in_ready=1 next cycle and the group is accepted, giving count=8 and full=1.
- Push in_valid=2'b10 with pc 0xA. Required: stored at a single slot and shown on out lane 0, count=1, out_valid=2'b01.
- Wrap: push and pop until head=6, then push 4 entries. Required: out_pc order is preserved across index 7→0.
- Simultaneous push of 2 and out_accept=2'b01 at count=3. Required: count=4. out_accept=2'b10. Required: no pop.
- Flush alongside push and pop. Required: count=0 and out_valid=0 next cycle. Assert rst mid-stream. Required: outputs clear immediately, without a clock edge.
